// File: rtl/fpadd_issue_ctrl.sv
// Issue stage for the combinational FP32 adder: buffers operand pairs, drives the
// adder from registered operands and resolves IEEE special cases locally.
module fpadd_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      add_src1,
  output logic [31:0]      add_src2,
  input  logic [31:0]      add_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [2:0]       res_flags,
  output logic [CNT_W-1:0] res_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  state_t          state_q;
  logic [31:0]     memA_q [DEPTH];
  logic [31:0]     memB_q [DEPTH];
  logic [AW:0]     wptr_q, rptr_q;
  logic [31:0]     src1_q, src2_q;
  logic            bypass_q;
  logic [31:0]     bypData_q;
  logic [2:0]      bypFlags_q;
  logic            resValid_q;
  logic [31:0]     resData_q;
  logic [2:0]      resFlags_q;
  logic [CNT_W-1:0] resCount_q;

  logic        full, empty, push, pop;
  logic [31:0] headA, headB;
  logic        aNan, bNan, aInf, bInf, aZero, bZero;
  logic        bypass_d, invalid_d, inf_d;
  logic [31:0] bypData_d;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign push  = in_valid && !full;
  assign pop   = !empty && ((state_q == IDLE) || ((state_q == HOLD) && res_ready));

  assign in_ready  = !full;
  assign add_src1  = src1_q;
  assign add_src2  = src2_q;
  assign res_valid = resValid_q;
  assign res_data  = resData_q;
  assign res_flags = resFlags_q;
  assign res_count = resCount_q;

  assign headA = memA_q[rptr_q[AW-1:0]];
  assign headB = memB_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      memA_q[wptr_q[AW-1:0]] <= in_a;
      memB_q[wptr_q[AW-1:0]] <= in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_comb begin
    aNan  = (headA[30:23] == 8'hFF) && (headA[22:0] != '0);
    bNan  = (headB[30:23] == 8'hFF) && (headB[22:0] != '0);
    aInf  = (headA[30:23] == 8'hFF) && (headA[22:0] == '0);
    bInf  = (headB[30:23] == 8'hFF) && (headB[22:0] == '0);
    aZero = (headA[30:0] == '0);
    bZero = (headB[30:0] == '0);
    bypass_d  = 1'b1;
    invalid_d = 1'b0;
    inf_d     = 1'b0;
    bypData_d = '0;
    if (aNan || bNan) begin
      bypData_d = 32'h7FC00000;
      invalid_d = 1'b1;
    end else if (aInf && bInf && (headA[31] != headB[31])) begin
      bypData_d = 32'h7FC00000;
      invalid_d = 1'b1;
    end else if (aInf) begin
      bypData_d = headA;
      inf_d     = 1'b1;
    end else if (bInf) begin
      bypData_d = headB;
      inf_d     = 1'b1;
    end else if (aZero && bZero) begin
      bypData_d = {headA[31] & headB[31], 31'b0};
    end else if (aZero) begin
      bypData_d = headB;
    end else if (bZero) begin
      bypData_d = headA;
    end else if ((headA ^ headB) == 32'h80000000) begin
      bypData_d = '0;
    end else begin
      bypass_d = 1'b0;
    end
  end

  // res_valid drops on every handshake so a result is never presented twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      src1_q     <= '0;
      src2_q     <= '0;
      bypass_q   <= 1'b0;
      bypData_q  <= '0;
      bypFlags_q <= '0;
      resValid_q <= 1'b0;
      resData_q  <= '0;
      resFlags_q <= '0;
      resCount_q <= '0;
    end else begin
      if (pop) begin
        src1_q     <= headA;
        src2_q     <= headB;
        bypass_q   <= bypass_d;
        bypData_q  <= bypData_d;
        bypFlags_q <= {bypass_d, invalid_d, inf_d};
      end
      case (state_q)
        IDLE: begin
          if (!empty) state_q <= EVAL;
        end
        EVAL: begin
          resValid_q <= 1'b1;
          if (bypass_q) begin
            resData_q  <= bypData_q;
            resFlags_q <= bypFlags_q;
          end else begin
            resData_q  <= add_out;
            resFlags_q <= {2'b00, add_out[30:23] == 8'hFF};
          end
          state_q <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            resCount_q <= resCount_q + CNT_W'(1);
            resValid_q <= 1'b0;
            state_q    <= empty ? IDLE : EVAL;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fpadd_issue_ctrl.md
Name: fpadd_issue_ctrl

Overview:
Upstream issue stage for the combinational FP32 adder. It accepts operand pairs on a valid/ready interface and buffers them in a small FIFO. Each pair is presented to the adder from registered operand outputs, and the adder result is captured into a registered, backpressured result port. IEEE special cases the adder does not handle (NaN, Inf, signed zero, exact cancellation) are resolved locally as bypass results.

Parameters:
DEPTH, 4, input FIFO entries (power of 2, >=2)
CNT_W, 16, width of delivered-result counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO not full
in_a  in  32  operand A (FP32)
in_b  in  32  operand B (FP32)
add_src1  out  32  registered operand to adder src1
add_src2  out  32  registered operand to adder src2
add_out  in  32  adder combinational result
res_valid  out  1  result valid
res_ready  in  1  downstream accepts result
res_data  out  32  FP32 result
res_flags  out  3  {bypass, invalid, inf}
res_count  out  CNT_W  results delivered, wraps

Behaviour:
- Reset (async, immediate): FIFO empty, state IDLE, add_src1/add_src2=0, res_valid=0, res_data=0, res_flags=0, res_count=0. in_ready=1 once rst deasserts. Reset mid-operation discards all buffered and in-flight pairs.
- Push: a pair is pushed when in_valid && in_ready at a clock edge.
- in_ready = !full, with no pass-through. A pop in the same cycle does not allow a push while full.
- FSM has 3 states:
  - IDLE: if the FIFO is non-empty, pop the head into add_src1/add_src2, latch its classification, and go to EVAL.
  - EVAL: lasts exactly 1 cycle so the adder settles. At the edge, load res_data/res_flags from the bypass value or add_out, set res_valid=1, and go to HOLD.
  - HOLD: res_valid=1 with data stable. On res_ready:
    - increment res_count;
    - if the FIFO is non-empty, pop the next pair and go to EVAL; otherwise clear res_valid and go to IDLE.
- Latency: a pair accepted at edge E0 into an empty FIFO in IDLE is popped at E1 and produces res_valid high after E2 (2 cycles). Throughput is 1 result per 2 cycles.
- Results are delivered strictly in FIFO order. No result is ever dropped or duplicated.
- Classification is computed at pop time, with exp=bits[30:23] and frac=bits[22:0]:
  - NaN: exp=255 and frac!=0. If either operand is NaN, the result is 32'h7FC00000 with flags {1,1,0}.
  - Inf vs Inf, opposite signs: result 32'h7FC00000, flags {1,1,0}.
  - Any other Inf: the Inf operand (sign preserved), flags {1,0,1}.
  - Both operands ±0: sign = a_sign & b_sign, flags {1,0,0}.
  - One operand ±0: result is the other operand, flags {1,0,0}.
  - Exact cancellation (a ^ b == 32'h80000000, non-zero): result 32'h00000000, flags {1,0,0}.
  - Otherwise use the adder path: res_data = add_out, bypass=0, invalid=0, inf=(add_out[30:23]==8'hFF).
- Bypass pairs still occupy the EVAL cycle, so timing is identical to the adder path.
- add_src1/add_src2 hold their value until the next pop.
- FIFO pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. full/empty are derived from pointer MSB/LSB compare.
- res_count increments on each res_valid && res_ready and wraps from all-ones to 0.

Test Plan:
- Adder path: push 3F800000+40000000 into idle block → add_src1/add_src2 driven after E1, res_data=40400000, flags=000, res_valid 2 cycles after accept, res_count=1 after handshake.
- NaN/Inf: push 7F800000+FF800000 → res_data=7FC00000, flags=110. Push 7FC00001+3F800000 → 7FC00000, flags=110. Push FF800000+3F800000 → FF800000, flags=101.
- Zeros: push 80000000+80000000 → 80000000. Push 00000000+3F800000 → 3F800000. Push 40490FDB+C0490FDB → 00000000. All three give flags=100.
- Backpressure: res_ready=0, offer 6 pairs back-to-back → exactly 5 accepted (1 in HOLD, 4 in FIFO) and in_ready=0. Release res_ready → 5 results in order, one per 2 cycles, then res_count=5 and in_ready=1.
- Wrap: push/drain 2*DEPTH+3 pairs with random stalls → all results match in order; FIFO pointer wrap exercised; empty/full never falsely asserted.
- Reset mid-flight: assert rst during HOLD with 3 pairs buffered → res_valid=0 immediately (asynchronously), res_count=0. After release: in_ready=1, no stale result ever emitted.
